// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with start/abort session control and a target match count.
// Define SEQ_OVERLAP_EN to keep history after a match (overlapping detection); default is non-overlapping.
module seq_detect_ctrl #(
   parameter int MAXLEN = 8,
   parameter int CNTW   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [MAXLEN-1:0]            cfg_pattern,
   input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
   input  logic [CNTW-1:0]              cfg_target,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         bit_valid,
   input  logic                         bit_in,
   output logic                         bit_ready,
   output logic                         match,
   output logic [CNTW-1:0]              match_count,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int LW = $clog2(MAXLEN+1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                err_q, err_d;
   logic                match_q, match_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [MAXLEN-1:0]   pat_q, pat_d;
   logic [LW-1:0]       len_q, len_d;
   logic [CNTW-1:0]     tgt_q, tgt_d;
   logic [MAXLEN-1:0]   hist_q, hist_d;
   logic [LW-1:0]       fill_q, fill_d;

   logic [MAXLEN-1:0]   len_mask;
   logic [MAXLEN-1:0]   hist_shift;
   logic [LW:0]         fill_inc;
   logic [LW-1:0]       fill_sat;
   logic [CNTW-1:0]     cnt_inc;
   logic                hit;
   logic                cfg_ok;

   // Only the low len bits of history and pattern take part in the compare.
   for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
      assign len_mask[gi] = ({1'b0, len_q} > (LW+1)'(gi));
   end

   assign hist_shift = {hist_q[MAXLEN-2:0], bit_in};
   assign fill_inc   = {1'b0, fill_q} + (LW+1)'(1);
   assign fill_sat   = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[LW-1:0];
   assign cnt_inc    = cnt_q + CNTW'(1);
   assign hit        = (fill_inc >= {1'b0, len_q}) &&
                       ((hist_shift & len_mask) == (pat_q & len_mask));
   assign cfg_ok     = (cfg_len != '0) && ({1'b0, cfg_len} <= (LW+1)'(MAXLEN)) &&
                       (cfg_target != '0);

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      len_d   = len_q;
      tgt_d   = tgt_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d = S_LOAD;
                  err_d   = 1'b0;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               pat_d   = cfg_pattern;
               len_d   = cfg_len;
               tgt_d   = cfg_target;
               hist_d  = '0;
               fill_d  = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // An abort swallows any bit handshaken in the same cycle.
            if (abort) begin
               state_d = S_IDLE;
            end else if (bit_valid) begin
               hist_d = hist_shift;
               fill_d = fill_sat;
               if (hit) begin
                  cnt_d   = cnt_inc;
                  match_d = 1'b1;
`ifndef SEQ_OVERLAP_EN
                  hist_d  = '0;
                  fill_d  = '0;
`endif
                  if (cnt_inc == tgt_q) state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         tgt_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         tgt_q   <= tgt_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
      end
   end

   assign bit_ready   = (state_q == S_RUN);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign match       = match_q;
   assign match_count = cnt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
// Honours SEQ_OVERLAP_EN the same way as the design.
module tb_seq_detect_ctrl;

   localparam int MAXLEN = 8;
   localparam int CNTW   = 8;
   localparam int LW     = $clog2(MAXLEN+1);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [MAXLEN-1:0]   cfg_pattern = '0;
   logic [LW-1:0]       cfg_len = '0;
   logic [CNTW-1:0]     cfg_target = '0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic                bit_valid = 1'b0;
   logic                bit_in = 1'b0;
   logic                bit_ready;
   logic                match;
   logic [CNTW-1:0]     match_count;
   logic                busy;
   logic                done;
   logic                err;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
      .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
      .bit_ready(bit_ready), .match(match), .match_count(match_count),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: session phase plus a queue of received bits.
   int m_phase = 0;      // 0 idle, 1 load, 2 run, 3 done
   bit m_err = 0;
   bit m_match = 0;
   int m_cnt = 0;
   int m_len = 0;
   int m_tgt = 0;
   bit [MAXLEN-1:0] m_pat = '0;
   bit m_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_err = 0; m_match = 0; m_cnt = 0; m_q.delete();
      end else begin
         m_match = 0;
         case (m_phase)
            0: if (start) begin
                  if (cfg_len >= 1 && cfg_len <= MAXLEN && cfg_target != 0) begin
                     m_phase = 1; m_err = 0;
                  end else m_err = 1;
               end
            1: if (abort) m_phase = 0;
               else begin
                  m_pat = cfg_pattern; m_len = int'(cfg_len); m_tgt = int'(cfg_target);
                  m_q.delete(); m_cnt = 0; m_phase = 2;
               end
            2: if (abort) m_phase = 0;
               else if (bit_valid) begin
                  bit hit;
                  m_q.push_back(bit_in);
                  while (m_q.size() > m_len) void'(m_q.pop_front());
                  hit = (m_q.size() == m_len);
                  for (int k = 0; k < m_len; k++)
                     if (m_q[m_len-1-k] != m_pat[k]) hit = 0;
                  if (hit) begin
                     m_cnt++; m_match = 1;
`ifndef SEQ_OVERLAP_EN
                     m_q.delete();
`endif
                     if (m_cnt == m_tgt) m_phase = 3;
                  end
               end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_bit_ready", int'(bit_ready), int'(m_phase == 2));
         chk("model_busy", int'(busy), int'(m_phase != 0));
         chk("model_done", int'(done), int'(m_phase == 3));
         chk("model_match", int'(match), int'(m_match));
         chk("model_count", int'(match_count), m_cnt);
         chk("model_err", int'(err), int'(m_err));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic begin_session(input logic [MAXLEN-1:0] p, input int l, input int t);
      cfg_pattern = p; cfg_len = LW'(l); cfg_target = CNTW'(t);
      start = 1'b1; cyc(); start = 1'b0;
      chk("lit_load_busy", int'(busy), 1);
      cyc();
      chk("lit_run_ready", int'(bit_ready), 1);
   endtask

   initial begin
      logic [6:0] s1;
      int m1, m2;
      s1 = 7'b1010101;
`ifdef SEQ_OVERLAP_EN
      m1 = 2; m2 = 4;
`else
      m1 = 2; m2 = 6;
`endif
      cyc(); cyc();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("lit_reset_busy", int'(busy), 0);
      chk("lit_reset_count", int'(match_count), 0);
      chk("lit_reset_err", int'(err), 0);

      // Match timing: 101, target 2, stream 1010101
      begin_session(8'b101, 3, 2);
      for (int i = 0; i < 7; i++) begin
         bit_valid = 1'b1; bit_in = s1[6-i];
         cyc();
         chk($sformatf("lit_t1_match_b%0d", i+1), int'(match), int'(i == m1 || i == m2));
         if (i == m1) chk("lit_t1_count1", int'(match_count), 1);
         if (i == m2) begin
            chk("lit_t1_count2", int'(match_count), 2);
            chk("lit_t1_done", int'(done), 1);
            chk("lit_t1_ready_low", int'(bit_ready), 0);
         end
         if (i == m2 + 1) chk("lit_t1_idle", int'(busy), 0);
      end
      bit_valid = 1'b0;
      cyc();
      chk("lit_t1_hold", int'(match_count), 2);

      // Invalid configurations then a valid start
      cfg_len = '0; cfg_target = 8'd3; start = 1'b1; cyc(); start = 1'b0;
      chk("lit_inv_len_err", int'(err), 1);
      chk("lit_inv_len_busy", int'(busy), 0);
      cfg_len = 4'd4; cfg_target = '0; start = 1'b1; cyc(); start = 1'b0;
      chk("lit_inv_tgt_err", int'(err), 1);
      chk("lit_inv_tgt_busy", int'(busy), 0);
      cyc();
      chk("lit_err_sticky", int'(err), 1);

      // Abort after one match: 1100, target 3
      begin_session(8'b1100, 4, 3);
      chk("lit_err_cleared", int'(err), 0);
      for (int i = 0; i < 7; i++) begin
         bit_valid = 1'b1; bit_in = (i % 4) < 2;
         cyc();
      end
      chk("lit_ab_count_pre", int'(match_count), 1);
      abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
      cyc();
      abort = 1'b0; bit_valid = 1'b0;
      chk("lit_ab_idle", int'(busy), 0);
      chk("lit_ab_nomatch", int'(match), 0);
      chk("lit_ab_nodone", int'(done), 0);
      chk("lit_ab_count", int'(match_count), 1);
      cyc();
      chk("lit_ab_hold", int'(match_count), 1);

      // Stall and configuration isolation: 11, target 1
      begin_session(8'b11, 2, 1);
      for (int i = 0; i < 4; i++) begin
         bit_valid = (i % 2) == 1; bit_in = (i % 2) == 1;
         if (i == 2) begin cfg_pattern = 8'b00; cfg_len = 4'd3; end
         cyc();
         chk($sformatf("lit_st_match_%0d", i), int'(match), int'(i == 3));
      end
      chk("lit_st_done", int'(done), 1);
      chk("lit_st_count", int'(match_count), 1);
      bit_valid = 1'b0;
      cyc();

      // Reset during RUN
      begin_session(8'b11, 2, 3);
      bit_valid = 1'b1; bit_in = 1'b1; cyc(); cyc();
      chk("lit_rs_count_pre", int'(match_count), 1);
      rst = 1'b1; bit_valid = 1'b0; cyc(); rst = 1'b0;
      chk("lit_rs_busy", int'(busy), 0);
      chk("lit_rs_ready", int'(bit_ready), 0);
      chk("lit_rs_count", int'(match_count), 0);
      chk("lit_rs_match", int'(match), 0);
      chk("lit_rs_done", int'(done), 0);
      chk("lit_rs_err", int'(err), 0);
      cyc(); cyc();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
